// File: rtl/msdap_pkg.sv
// Shared constants for the rj memory bank: default geometry and channel ids.
package msdap_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int DEPTH_DEFAULT  = 16;

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

endpackage

// File: rtl/rj_channel_mem.sv
// One channel of rj storage: a DEPTH x DATA_W array filled in order by a
// non-wrapping write pointer, plus the flag that marks the channel as full.
module rj_channel_mem
  import msdap_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              reload,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_word,
  output logic              load_done
);

  // Pointer value of the final slot; accepting a write here fills the channel.
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [ADDR_W:0]   ptr_r;
  logic              done_r;
  logic              accept_s;

  // A write lands only while the channel is still loading and no clear or reload overrides it.
  always_comb begin
    accept_s = 1'b0;
    if (wr_req && !done_r && !reload && !clear) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Write pointer and full flag; the pointer stops at DEPTH because a full channel accepts nothing.
  always_ff @(posedge clk) begin
    if (clear) begin
      ptr_r  <= '0;
      done_r <= 1'b0;
    end else if (reload) begin
      ptr_r  <= '0;
      done_r <= 1'b0;
    end else if (accept_s) begin
      ptr_r <= ptr_r + (ADDR_W + 1)'(1);
      if (ptr_r == LAST_PTR) begin
        done_r <= 1'b1;
      end
    end
  end

  // Storage array, deliberately not reset so contents survive clear and reload.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[ptr_r[ADDR_W-1:0]] <= wr_data;
    end
  end

  // Asynchronous array read; the top registers it, giving read-before-write on a shared address.
  always_comb begin
    rd_word = mem_r[rd_addr];
  end

  assign load_done = done_r;

endmodule

// File: rtl/rj_memory_bank.sv
// Two-channel rj memory bank: steers writes to the left/right channel, muxes
// reads into a one-cycle registered port and tracks rejected writes.
module rj_memory_bank
  import msdap_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              Sclk,
  input  logic              Clear,
  input  logic              reload,
  input  logic              wr_en,
  input  logic              wr_ch,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_ch,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [1:0]        load_done,
  output logic              overflow
);

  logic [1:0]        wr_req_s;
  logic [DATA_W-1:0] word_l_s;
  logic [DATA_W-1:0] word_r_s;
  logic [DATA_W-1:0] rd_next_s;
  logic [1:0]        done_s;
  logic [DATA_W-1:0] rd_data_r;
  logic              rd_valid_r;
  logic              overflow_r;

  // Route the write strobe to the selected channel only.
  always_comb begin
    wr_req_s = 2'b00;
    if (wr_en) begin
      if (wr_ch == CH_R) begin
        wr_req_s = 2'b10;
      end else begin
        wr_req_s = 2'b01;
      end
    end else begin
      wr_req_s = 2'b00;
    end
  end

  rj_channel_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem_l (
    .clk       (Sclk),
    .clear     (Clear),
    .reload    (reload),
    .wr_req    (wr_req_s[0]),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_word   (word_l_s),
    .load_done (done_s[0])
  );

  rj_channel_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem_r (
    .clk       (Sclk),
    .clear     (Clear),
    .reload    (reload),
    .wr_req    (wr_req_s[1]),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_word   (word_r_s),
    .load_done (done_s[1])
  );

  // Select the read channel; a channel that is still loading reads as zero.
  always_comb begin
    rd_next_s = '0;
    if (rd_ch == CH_R) begin
      if (done_s[1]) begin
        rd_next_s = word_r_s;
      end else begin
        rd_next_s = '0;
      end
    end else begin
      if (done_s[0]) begin
        rd_next_s = word_l_s;
      end else begin
        rd_next_s = '0;
      end
    end
  end

  // Registered read port: valid for one cycle per request, data held between reads.
  always_ff @(posedge Sclk) begin
    if (Clear) begin
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
    end else if (rd_en) begin
      rd_data_r  <= rd_next_s;
      rd_valid_r <= 1'b1;
    end else begin
      rd_valid_r <= 1'b0;
    end
  end

  // Sticky overflow: set by a write to a full channel unless reload wins the same cycle.
  always_ff @(posedge Sclk) begin
    if (Clear) begin
      overflow_r <= 1'b0;
    end else if (reload) begin
      overflow_r <= 1'b0;
    end else if (wr_en && done_s[wr_ch]) begin
      overflow_r <= 1'b1;
    end
  end

  assign rd_data   = rd_data_r;
  assign rd_valid  = rd_valid_r;
  assign load_done = done_s;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_rj_memory_bank.sv
// Self-checking bench for rj_memory_bank: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_rj_memory_bank;

  localparam int DW = 16;
  localparam int DP = 16;
  localparam int AW = 4;

  logic          Sclk = 1'b0;
  logic          Clear;
  logic          reload;
  logic          wr_en;
  logic          wr_ch;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic          rd_ch;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [1:0]    load_done;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model state.
  logic [DW-1:0] m_mem [2][DP];
  int            m_cnt [2];
  logic [DW-1:0] m_rd_data;
  logic          m_rd_valid;
  logic          m_ovf;

  rj_memory_bank #(.DATA_W(DW), .DEPTH(DP)) dut (
    .Sclk      (Sclk),
    .Clear     (Clear),
    .reload    (reload),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_ch     (rd_ch),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .load_done (load_done),
    .overflow  (overflow)
  );

  always #5 Sclk = ~Sclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a channel counts accepted words; it is full once it has DP of them.
  always @(posedge Sclk) begin
    if (Clear) begin
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
      m_ovf      = 1'b0;
      m_cnt[0]   = 0;
      m_cnt[1]   = 0;
    end else begin
      if (rd_en) begin
        m_rd_valid = 1'b1;
        m_rd_data  = (m_cnt[rd_ch] == DP) ? m_mem[rd_ch][rd_addr] : '0;
      end else begin
        m_rd_valid = 1'b0;
      end
      if (reload) begin
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        m_ovf    = 1'b0;
      end else if (wr_en) begin
        if (m_cnt[wr_ch] == DP) begin
          m_ovf = 1'b1;
        end else begin
          m_mem[wr_ch][m_cnt[wr_ch]] = wr_data;
          m_cnt[wr_ch]++;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge Sclk) begin
    if (chk_en) begin
      check("cyc_rd_valid", {31'd0, rd_valid}, {31'd0, m_rd_valid});
      check("cyc_rd_data", {16'd0, rd_data}, {16'd0, m_rd_data});
      check("cyc_load_done", {30'd0, load_done}, {30'd0, (m_cnt[1] == DP), (m_cnt[0] == DP)});
      check("cyc_overflow", {31'd0, overflow}, {31'd0, m_ovf});
    end
  end

  task automatic tick();
    @(posedge Sclk);
    #1;
  endtask

  task automatic idle();
    Clear = 1'b0; reload = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic wr(input logic ch, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_ch = ch; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input string name, input logic ch, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rd_en = 1'b1; rd_ch = ch; rd_addr = a;
    tick();
    rd_en = 1'b0;
    check({name, "_valid"}, {31'd0, rd_valid}, 32'd1);
    check({name, "_data"}, {16'd0, rd_data}, {16'd0, exp});
  endtask

  initial begin
    for (int c = 0; c < 2; c++) begin
      for (int a = 0; a < DP; a++) m_mem[c][a] = '0;
    end
    Clear = 1'b1; reload = 1'b0; wr_en = 1'b0; wr_ch = 1'b0; wr_data = '0;
    rd_en = 1'b0; rd_ch = 1'b0; rd_addr = '0;
    tick();
    chk_en = 1'b1;
    tick();
    idle();
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_rd_data", {16'd0, rd_data}, 32'd0);
    check("rst_load_done", {30'd0, load_done}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);

    // Fill the left channel with 0x0100..0x010F.
    for (int i = 0; i < DP; i++) begin
      wr(1'b0, 16'h0100 + 16'(i));
      if (i == DP - 2) check("ld_not_yet", {30'd0, load_done}, 32'd0);
    end
    check("ld_left_done", {30'd0, load_done}, 32'd1);
    rd("rd_l5", 1'b0, 4'd5, 16'h0105);

    // Overflow on a full channel leaves contents intact.
    wr(1'b0, 16'hBEEF);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    rd("rd_l0_after_ovf", 1'b0, 4'd0, 16'h0100);
    rd("rd_l15", 1'b0, 4'd15, 16'h010F);
    tick();
    check("hold_valid", {31'd0, rd_valid}, 32'd0);
    check("hold_data", {16'd0, rd_data}, 32'h010F);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Right channel reads as zero before it is loaded.
    rd("rd_r_unloaded", 1'b1, 4'd3, 16'h0000);

    // Reload beats a write in the same cycle and is not flagged.
    reload = 1'b1; wr_en = 1'b1; wr_ch = 1'b0; wr_data = 16'hDEAD;
    tick();
    idle();
    check("reload_ovf", {31'd0, overflow}, 32'd0);
    check("reload_done", {30'd0, load_done}, 32'd0);
    rd("rd_l_after_reload", 1'b0, 4'd0, 16'h0000);

    // Interleaved load of both channels.
    for (int i = 0; i < DP; i++) begin
      wr(1'b0, 16'h0200 + 16'(i));
      wr(1'b1, (i == 0) ? 16'h2222 : 16'h0300 + 16'(i));
    end
    check("ld_both_done", {30'd0, load_done}, 32'd3);
    rd("rd_l0_reloaded", 1'b0, 4'd0, 16'h0200);
    rd("rd_r0", 1'b1, 4'd0, 16'h2222);

    // Simultaneous write and read of right address 0 returns the old word.
    wr_en = 1'b1; wr_ch = 1'b1; wr_data = 16'h1111;
    rd("rbw_full", 1'b1, 4'd0, 16'h2222);
    wr_en = 1'b0;
    check("rbw_full_ovf", {31'd0, overflow}, 32'd1);

    // After reload the same collision writes address 0 but reads the loading channel as zero.
    reload = 1'b1;
    tick();
    reload = 1'b0;
    wr_en = 1'b1; wr_ch = 1'b1; wr_data = 16'h1111;
    rd("rbw_loading", 1'b1, 4'd0, 16'h0000);
    wr_en = 1'b0;
    for (int i = 0; i < DP - 1; i++) wr(1'b1, 16'h0600 + 16'(i));
    check("ld_right_only", {30'd0, load_done}, 32'd2);
    rd("rd_r0_new", 1'b1, 4'd0, 16'h1111);

    // Back-to-back reads with no bubbles.
    rd_en = 1'b1; rd_ch = 1'b1;
    for (int a = 1; a <= 3; a++) begin
      rd_addr = 4'(a);
      tick();
      check("b2b_valid", {31'd0, rd_valid}, 32'd1);
      check("b2b_data", {16'd0, rd_data}, {16'd0, 16'h0600 + 16'(a - 1)});
    end
    rd_en = 1'b0;

    // Write to the left channel does not disturb a right-channel read.
    wr_en = 1'b1; wr_ch = 1'b0; wr_data = 16'h7777;
    rd("cross_ch", 1'b1, 4'd5, 16'h0604);
    wr_en = 1'b0;

    // Clear beats everything else in the same cycle.
    Clear = 1'b1; reload = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    idle();
    check("clr_prio_valid", {31'd0, rd_valid}, 32'd0);
    check("clr_prio_data", {16'd0, rd_data}, 32'd0);
    check("clr_prio_done", {30'd0, load_done}, 32'd0);

    // Clear part-way through a load restarts it at address 0.
    for (int i = 0; i < 7; i++) wr(1'b0, 16'h0400 + 16'(i));
    Clear = 1'b1;
    tick();
    idle();
    wr(1'b0, 16'hAAAA);
    for (int i = 0; i < DP - 1; i++) begin
      if (i == DP - 2) check("clr_ld_not_yet", {30'd0, load_done}, 32'd0);
      wr(1'b0, 16'h0500 + 16'(i));
    end
    check("clr_ld_done", {30'd0, load_done}, 32'd1);
    rd("clr_rd0", 1'b0, 4'd0, 16'hAAAA);
    rd("clr_rd1", 1'b0, 4'd1, 16'h0500);

    tick();
    tick();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
